// File: rtl/vga_timing_gen.sv
// Raster timing for 640x480@60: pixel coordinates, blank, and
// PIPE_DELAY-aligned active-low sync pulses on vga_clk.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 2
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0] hc_nxt;
   logic [9:0] vc_nxt;
   logic       last_col;
   logic       last_row;
   logic       blank_nxt;
   logic       hs_nxt;
   logic       vs_nxt;
   logic       fs_nxt;
   logic       hs_raw;
   logic       vs_raw;

   // Decodes use the next counter values so they register with them.
   always_comb begin
      last_col = (DrawX >= H_MAX);
      last_row = (DrawY >= V_MAX);
      hc_nxt   = last_col ? 10'd0 : DrawX + 10'd1;
      vc_nxt   = DrawY;
      if (last_col) begin
         vc_nxt = last_row ? 10'd0 : DrawY + 10'd1;
      end
      blank_nxt = (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
      hs_nxt    = !((hc_nxt >= HS_BEG) && (hc_nxt < HS_END));
      vs_nxt    = !((vc_nxt >= VS_BEG) && (vc_nxt < VS_END));
      fs_nxt    = (hc_nxt < 10'd1) && (vc_nxt < 10'd1);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         DrawX       <= H_MAX;
         DrawY       <= V_MAX;
         blank       <= 1'b0;
         hs_raw      <= 1'b1;
         vs_raw      <= 1'b1;
         frame_start <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         DrawX       <= hc_nxt;
         DrawY       <= vc_nxt;
         blank       <= blank_nxt;
         hs_raw      <= hs_nxt;
         vs_raw      <= vs_nxt;
         frame_start <= fs_nxt;
         if (fs_nxt) begin
            frame_count <= frame_count + 8'd1;
         end
      end
   end

   // Sync delay line matches the downstream ROM/RGB latency.
   generate
      if (PIPE_DELAY == 0) begin : g_nodly
         assign hs = hs_raw;
         assign vs = vs_raw;
      end else begin : g_dly
         logic [PIPE_DELAY-1:0] hs_dly;
         logic [PIPE_DELAY-1:0] vs_dly;

         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               hs_dly <= '1;
               vs_dly <= '1;
            end else begin
               hs_dly[0] <= hs_raw;
               vs_dly[0] <= vs_raw;
               for (int i = 1; i < PIPE_DELAY; i++) begin
                  hs_dly[i] <= hs_dly[i-1];
                  vs_dly[i] <= vs_dly[i-1];
               end
            end
         end

         assign hs = hs_dly[PIPE_DELAY-1];
         assign vs = vs_dly[PIPE_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: arithmetic raster model checked every
// cycle on a full-size and two shrunken instances.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       b;
      logic       h;
      logic       v;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   logic       vga_clk;
   logic       reset_n;
   int         t;
   int         checks;
   int         failures;
   bit         run_chk;

   logic [9:0] f_x, f_y, s_x, s_y, z_x, z_y;
   logic       f_b, f_h, f_v, f_fs;
   logic       s_b, s_h, s_v, s_fs;
   logic       z_b, z_h, z_v, z_fs;
   logic [7:0] f_fc, s_fc, z_fc;

   vga_timing_gen #(.PIPE_DELAY(2)) u_full (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(f_x), .DrawY(f_y), .blank(f_b),
      .hs(f_h), .vs(f_v),
      .frame_start(f_fs), .frame_count(f_fc)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIPE_DELAY(2)
   ) u_small (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(s_x), .DrawY(s_y), .blank(s_b),
      .hs(s_h), .vs(s_v),
      .frame_start(s_fs), .frame_count(s_fc)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIPE_DELAY(0)
   ) u_small0 (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(z_x), .DrawY(z_y), .blank(z_b),
      .hs(z_h), .vs(z_v),
      .frame_start(z_fs), .frame_count(z_fc)
   );

   initial begin
      vga_clk = 1'b0;
      forever #5 vga_clk = ~vga_clk;
   end

   // Cycle index since the first edge after reset release; -1 in reset.
   always @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) t <= -1;
      else          t <= t + 1;
   end

   function automatic exp_t model(
      input int tt,
      input int hv, input int hf, input int hsw, input int hb,
      input int vv, input int vf, input int vsw, input int vb,
      input int pd
   );
      exp_t m;
      int ht, vt, ft, x, y, td, xd, yd;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      ft = ht * vt;
      if (tt < 0) begin
         m.x = 10'(ht - 1);
         m.y = 10'(vt - 1);
         m.b = 1'b0;
         m.h = 1'b1;
         m.v = 1'b1;
         m.fs = 1'b0;
         m.fc = 8'd0;
         return m;
      end
      x = tt % ht;
      y = (tt / ht) % vt;
      m.x = 10'(x);
      m.y = 10'(y);
      m.b = (x < hv) && (y < vv);
      m.fs = (tt % ft) == 0;
      m.fc = 8'(((tt / ft) + 1) % 256);
      td = tt - pd;
      if (td < 0) begin
         m.h = 1'b1;
         m.v = 1'b1;
      end else begin
         xd = td % ht;
         yd = (td / ht) % vt;
         m.h = !((xd >= hv + hf) && (xd < hv + hf + hsw));
         m.v = !((yd >= vv + vf) && (yd < vv + vf + vsw));
      end
      return m;
   endfunction

   task automatic cmp(input string nm, input exp_t a, input exp_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s t=%0d got x=%0d y=%0d b=%b h=%b v=%b fs=%b fc=%0d want x=%0d y=%0d b=%b h=%b v=%b fs=%b fc=%0d",
                  nm, t, a.x, a.y, a.b, a.h, a.v, a.fs, a.fc,
                  e.x, e.y, e.b, e.h, e.v, e.fs, e.fc);
      end
   endtask

   task automatic lit(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   // Per-cycle model compare plus run-length checks.
   initial begin
      int hs_run, bh_run, vs_run, fs_prev;
      exp_t a, e;
      hs_run = 0; bh_run = 0; vs_run = 0; fs_prev = -1;
      forever begin
         @(negedge vga_clk);
         if (run_chk) begin
            a = '{f_x, f_y, f_b, f_h, f_v, f_fs, f_fc};
            e = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 2);
            cmp("full", a, e);
            a = '{s_x, s_y, s_b, s_h, s_v, s_fs, s_fc};
            e = model(t, 8, 2, 3, 2, 4, 1, 2, 1, 2);
            cmp("small_pd2", a, e);
            a = '{z_x, z_y, z_b, z_h, z_v, z_fs, z_fc};
            e = model(t, 8, 2, 3, 2, 4, 1, 2, 1, 0);
            cmp("small_pd0", a, e);
            if (!reset_n) begin
               hs_run = 0; bh_run = 0; vs_run = 0; fs_prev = -1;
            end else begin
               if (!f_h) hs_run++;
               else if (hs_run > 0) begin
                  lit("full_hs_width", hs_run, 96);
                  hs_run = 0;
               end
               if (f_b) bh_run++;
               else if (bh_run > 0) begin
                  lit("full_blank_hi", bh_run, 640);
                  bh_run = 0;
               end
               if (!s_v) vs_run++;
               else if (vs_run > 0) begin
                  lit("small_vs_width", vs_run, 30);
                  vs_run = 0;
               end
               if (s_fs) begin
                  if (fs_prev >= 0) lit("small_frame_per", t - fs_prev, 120);
                  fs_prev = t;
               end
            end
         end
      end
   end

   task automatic wait_small(input int x, input int y,
                             input int budget, input string nm);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge vga_clk);
         if (s_x == 10'(x) && s_y == 10'(y)) found = 1'b1;
      end
      if (!found) begin
         failures++;
         $display("FAIL %s timeout waiting for (%0d,%0d)", nm, x, y);
      end
   endtask

   initial begin
      int nfs;
      bit done;
      checks = 0;
      failures = 0;
      run_chk = 1'b0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      lit("rst_full_x", int'(f_x), 799);
      lit("rst_full_y", int'(f_y), 524);
      lit("rst_full_hsvs", int'({f_h, f_v}), 3);
      lit("rst_small_x", int'(s_x), 14);
      lit("rst_small_y", int'(s_y), 7);
      run_chk = 1'b1;
      repeat (5) @(negedge vga_clk);
      #2 reset_n = 1'b1;

      @(negedge vga_clk);
      lit("first_x", int'(f_x), 0);
      lit("first_y", int'(f_y), 0);
      lit("first_blank", int'(f_b), 1);
      lit("first_fs", int'(f_fs), 1);
      lit("first_fc", int'(f_fc), 1);

      wait_small(14, 2, 200, "wrap_line");
      @(negedge vga_clk);
      lit("wrap_line_x", int'(s_x), 0);
      lit("wrap_line_y", int'(s_y), 3);
      lit("wrap_line_fs", int'(s_fs), 0);

      wait_small(14, 7, 200, "wrap_frame");
      @(negedge vga_clk);
      lit("wrap_frame_xy", int'({s_x, s_y}), 0);
      lit("wrap_frame_fs", int'(s_fs), 1);
      lit("wrap_frame_fc", int'(s_fc), 2);

      // Two frames have started; run until the 256th.
      nfs = 2;
      done = 1'b0;
      for (int i = 0; i < 31000 && !done; i++) begin
         @(negedge vga_clk);
         if (s_fs) nfs++;
         if (nfs >= 256) done = 1'b1;
      end
      if (!done) begin
         failures++;
         $display("FAIL fc_wrap timeout frames=%0d", nfs);
      end
      lit("fc_wrap_small", int'(s_fc), 0);
      lit("fc_wrap_small0", int'(z_fc), 0);

      wait_small(13, 5, 200, "mid_reset");
      lit("pre_rst_hs", int'(s_h), 0);
      lit("pre_rst_vs", int'(s_v), 0);
      #2 reset_n = 1'b0;
      #1;
      lit("async_hs", int'(s_h), 1);
      lit("async_vs", int'(s_v), 1);
      lit("async_hs0", int'(z_h), 1);
      lit("async_x", int'(s_x), 14);
      lit("async_fc", int'(s_fc), 0);
      repeat (3) @(negedge vga_clk);
      #2 reset_n = 1'b1;

      repeat (400) @(negedge vga_clk);
      run_chk = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator producing the pixel coordinate stream (DrawX, DrawY, blank) consumed by the tile mappers and sprite drawers, plus VGA sync pulses to the pins. Runs entirely on vga_clk (25 MHz, 640x480@60). It is the source end of the coordinate/blank interface: mappers sample DrawX/DrawY, look up ROM/palette with a fixed latency, and drive RGB. hs/vs are delayed by that latency so the sync pins stay aligned with the colour pins.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (H_TOTAL = sum = 800)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch (V_TOTAL = sum = 525)
- PIPE_DELAY, 2, downstream colour latency in cycles (ROM read + RGB register); legal 0..7
- vga_clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  current horizontal position, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel (DrawX < H_VISIBLE and DrawY < V_VISIBLE), 0 = blanked; aligned with DrawX/DrawY
- hs  out  1  horizontal sync, active-low, delayed PIPE_DELAY cycles
- vs  out  1  vertical sync, active-low, delayed PIPE_DELAY cycles
- frame_start  out  1  one-cycle pulse when (DrawX, DrawY) = (0, 0)
- frame_count  out  8  frames started since reset, wraps 255 -> 0

## Operation
- All outputs registered; no combinational path from any input to any output.
- Horizontal counter hc advances every cycle; at H_TOTAL-1 it wraps to 0 and the vertical counter vc advances; vc wraps V_TOTAL-1 -> 0 on the same edge that hc wraps.
- DrawX = hc, DrawY = vc. blank, raw sync and frame_start are computed from the next counter values and registered with the counters, so all are coincident with DrawX/DrawY.
- Raw hs low iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751). Raw vs low iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491), for whole lines (hc-independent).
- hs/vs pins = raw sync through a PIPE_DELAY-stage shift register, each stage reset to 1. PIPE_DELAY = 0: pins equal raw sync.
- frame_count increments on the same edge frame_start rises.
- Arithmetic: counters 10 bits unsigned; compare with >= / < only, never ==, for range decodes.

## Timing
- Reset (reset_n low, asynchronous): DrawX = H_TOTAL-1 (799), DrawY = V_TOTAL-1 (524), blank = 0, hs = 1, vs = 1, all delay stages = 1, frame_start = 0, frame_count = 0.
- First rising edge after reset_n release: DrawX = 0, DrawY = 0, blank = 1, frame_start = 1, frame_count = 1.
- Line period H_TOTAL cycles; frame period H_TOTAL*V_TOTAL = 420000 cycles.
- blank falls on the edge DrawX becomes 640; rises on the edge DrawX becomes 0 on lines 0..479. Lines 480..524 blank = 0 throughout.
- hs falls PIPE_DELAY cycles after DrawX becomes 656; low exactly 96 cycles.
- vs low for exactly 2*H_TOTAL = 1600 cycles, falling PIPE_DELAY cycles after (DrawX, DrawY) becomes (0, 490).
- Reset asserted mid-frame: outputs go to reset values immediately (no clock needed); sequence restarts per the first-edge rule; no partial sync pulse leaks out of the delay line.

## Test plan
- Reset release: hold reset_n low 5 cycles -> outputs at reset values; first edge after release gives DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1.
- Line timing: count cycles across one line -> blank high 640 cycles, low 160; raw hs region 656..751; hs pin falls 2 cycles after DrawX=656, low 96 cycles.
- Frame timing: run 2 full frames -> frame_start pulses exactly once per 420000 cycles; vs low 1600 cycles starting 2 cycles after (0,490); blank never 1 with DrawY >= 480.
- Wrap: at (799, 524) next edge -> (0, 0), frame_start=1; at (799, 100) next edge -> (0, 101), frame_start=0.
- frame_count wrap: run 256 frames -> frame_count reads 0 after the 256th frame_start.
- Mid-frame reset: assert reset_n low during hs-low at DrawY=490 -> hs=vs=1 asynchronously; after release, no sync low until the new frame reaches DrawX=656; PIPE_DELAY=0 build repeated with hs aligned to DrawX.
